// File: rtl/fp_pkg.sv
// Shared binary64 field widths, special encodings and the unpacked operand view
// used by the FP add/sub datapath.
package fp_pkg;

  localparam int EXP_W  = 11;
  localparam int FRAC_W = 52;
  localparam int BIAS   = 1023;

  // Biased exponent value that encodes Inf/NaN; anything reaching it overflows.
  localparam int EXP_INF = 2 * BIAS + 1;

  localparam logic [63:0] FP64_QNAN    = 64'h7FF8000000000000;
  localparam logic [63:0] FP64_POS_INF = 64'h7FF0000000000000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W:0]   mant;
  } fp_unpacked_t;

endpackage

// File: rtl/fp_lzc.sv
// 64-bit leading-zero counter; an all-zero input reports 64.
module fp_lzc (
  input  logic [63:0] i_data,
  output logic [6:0]  o_count
);

  // Scanning upward lets the highest set bit win the last assignment.
  always_comb begin
    o_count = 7'd64;
    for (int i = 0; i < 64; i++) begin
      if (i_data[i]) o_count = 7'(63 - i);
    end
  end

endmodule

// File: rtl/fp_add_sub.sv
// IEEE-754 binary64 adder/subtractor, round-to-nearest-even, fully combinational
// datapath feeding a single 64-bit result register.
module fp_add_sub
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] fp_a_in,
  input  logic [63:0] fp_b_in,
  input  logic        is_sub,
  output logic [63:0] fp_res_out
);

  fp_unpacked_t      w_a, w_b, w_big, w_small;
  logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic              w_eff_sub, w_a_ge_b;
  logic [EXP_W-1:0]  w_exp_diff;
  logic [55:0]       w_small_ext, w_shifted, w_lost_mask, w_aligned;
  logic [56:0]       w_sum;
  logic [55:0]       w_diff;
  logic [6:0]        w_lz;
  logic [11:0]       w_max_shift, w_shamt;
  logic [55:0]       w_norm_mant;
  logic [11:0]       w_norm_exp, w_exp_out;
  logic              w_round_up;
  logic [53:0]       w_rounded;
  logic [FRAC_W-1:0] w_frac_out;
  logic [63:0]       w_res;
  logic [63:0]       r_res;

  // Subnormals get effective exponent 1 and no hidden bit; B carries its effective sign.
  always_comb begin
    w_a.sign = fp_a_in[63];
    w_a.exp  = (fp_a_in[62:52] == '0) ? 11'd1 : fp_a_in[62:52];
    w_a.mant = {|fp_a_in[62:52], fp_a_in[51:0]};
    w_b.sign = fp_b_in[63] ^ is_sub;
    w_b.exp  = (fp_b_in[62:52] == '0) ? 11'd1 : fp_b_in[62:52];
    w_b.mant = {|fp_b_in[62:52], fp_b_in[51:0]};
  end

  assign w_a_nan = (&fp_a_in[62:52]) & (|fp_a_in[51:0]);
  assign w_b_nan = (&fp_b_in[62:52]) & (|fp_b_in[51:0]);
  assign w_a_inf = (&fp_a_in[62:52]) & ~(|fp_a_in[51:0]);
  assign w_b_inf = (&fp_b_in[62:52]) & ~(|fp_b_in[51:0]);

  assign w_eff_sub = w_a.sign ^ w_b.sign;
  assign w_a_ge_b  = {w_a.exp, w_a.mant} >= {w_b.exp, w_b.mant};
  assign w_big     = w_a_ge_b ? w_a : w_b;
  assign w_small   = w_a_ge_b ? w_b : w_a;

  // Align into a 53+3 field; shifted-out bits jam into the sticky LSB.
  assign w_exp_diff  = w_big.exp - w_small.exp;
  assign w_small_ext = {w_small.mant, 3'b000};
  assign w_shifted   = w_small_ext >> w_exp_diff[5:0];
  assign w_lost_mask = ~({56{1'b1}} << w_exp_diff[5:0]);
  assign w_aligned   = (w_exp_diff >= 11'd56) ? {55'd0, |w_small.mant}
                     : {w_shifted[55:1], w_shifted[0] | (|(w_small_ext & w_lost_mask))};

  assign w_sum  = {1'b0, w_big.mant, 3'b000} + {1'b0, w_aligned};
  assign w_diff = {w_big.mant, 3'b000} - w_aligned;

  fp_lzc u_lzc (
    .i_data  ({w_diff, 8'h00}),
    .o_count (w_lz)
  );

  // Clamping the left shift at exponent 1 leaves a subnormal with bit 55 clear.
  assign w_max_shift = {1'b0, w_big.exp} - 12'd1;
  assign w_shamt     = ({5'd0, w_lz} > w_max_shift) ? w_max_shift : {5'd0, w_lz};

  always_comb begin
    w_norm_mant = w_sum[55:0];
    w_norm_exp  = {1'b0, w_big.exp};
    if (!w_eff_sub) begin
      if (w_sum[56]) begin
        w_norm_mant = {w_sum[56:2], w_sum[1] | w_sum[0]};
        w_norm_exp  = {1'b0, w_big.exp} + 12'd1;
      end
    end else begin
      w_norm_mant = w_diff << w_shamt;
      w_norm_exp  = {1'b0, w_big.exp} - w_shamt;
    end
  end

  assign w_round_up = w_norm_mant[2] & (w_norm_mant[1] | w_norm_mant[0] | w_norm_mant[3]);
  assign w_rounded  = {1'b0, w_norm_mant[55:3]} + {53'd0, w_round_up};

  // Leading bit position after rounding decides exponent bump, normal, or subnormal field.
  always_comb begin
    if (w_rounded[53]) begin
      w_exp_out  = w_norm_exp + 12'd1;
      w_frac_out = w_rounded[52:1];
    end else if (w_rounded[52]) begin
      w_exp_out  = w_norm_exp;
      w_frac_out = w_rounded[51:0];
    end else begin
      w_exp_out  = 12'd0;
      w_frac_out = w_rounded[51:0];
    end
  end

  always_comb begin
    w_res = {w_big.sign, w_exp_out[EXP_W-1:0], w_frac_out};
    if (w_a_nan || w_b_nan) begin
      w_res = FP64_QNAN;
    end else if (w_a_inf && w_b_inf && w_eff_sub) begin
      w_res = FP64_QNAN;
    end else if (w_a_inf) begin
      w_res = {w_a.sign, FP64_POS_INF[62:0]};
    end else if (w_b_inf) begin
      w_res = {w_b.sign, FP64_POS_INF[62:0]};
    end else if (w_norm_mant == '0) begin
      w_res = {w_a.sign & w_b.sign, 63'd0};
    end else if (w_exp_out >= 12'(EXP_INF)) begin
      w_res = {w_big.sign, FP64_POS_INF[62:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_res <= '0;
    else        r_res <= w_res;
  end

  assign fp_res_out = r_res;

endmodule

// File: tb/tb_fp_add_sub.sv
// Self-checking bench for fp_add_sub: directed vectors, reset behaviour, and
// randomized operands checked against host double-precision arithmetic.
module tb_fp_add_sub;

  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] fp_a_in = '0;
  logic [63:0] fp_b_in = '0;
  logic        is_sub = 1'b0;
  logic [63:0] fp_res_out;

  int vectors = 0;
  int miscompares = 0;

  fp_add_sub dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fp_a_in    (fp_a_in),
    .fp_b_in    (fp_b_in),
    .is_sub     (is_sub),
    .fp_res_out (fp_res_out)
  );

  always #5 clk = ~clk;

  function automatic logic isNan(input logic [63:0] v);
    return (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
  endfunction

  // Host doubles already implement IEEE RNE with subnormals; only NaNs need canonicalising.
  function automatic logic [63:0] refAddSub(input logic [63:0] a, input logic [63:0] b,
                                            input logic sub);
    real ra, rb, rr;
    logic [63:0] bits;
    if (isNan(a) || isNan(b)) return QNAN;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    rr = sub ? (ra - rb) : (ra + rb);
    bits = $realtobits(rr);
    if (isNan(bits)) return QNAN;
    return bits;
  endfunction

  function automatic logic [63:0] randOperand();
    logic [63:0] v;
    int kind;
    v = {$urandom(), $urandom()};
    kind = int'($urandom_range(0, 9));
    case (kind)
      0: ;
      1: v[62:52] = 11'd0;
      2: begin
        v[62:52] = 11'h7FF;
        if ($urandom_range(0, 2) != 0) v[51:0] = 52'd0;
      end
      3: v[62:0] = 63'd0;
      4: v[62:52] = 11'(2040 + $urandom_range(0, 6));
      5: v[62:52] = 11'(1 + $urandom_range(0, 3));
      6: begin
        v[62:52] = 11'(1000 + $urandom_range(0, 46));
        v[30:0]  = 31'd0;
      end
      default: v[62:52] = 11'(1000 + $urandom_range(0, 46));
    endcase
    return v;
  endfunction

  // Operand with an exponent close to a's, often sharing its fraction, to provoke cancellation.
  function automatic logic [63:0] nearOperand(input logic [63:0] a);
    logic [63:0] r, v;
    int e;
    r = {$urandom(), $urandom()};
    e = int'(a[62:52]);
    if (e == 2047) e = 2046;
    e = e + int'($urandom_range(0, 8)) - 4;
    if (e < 0) e = 0;
    if (e > 2046) e = 2046;
    v[63]    = r[63];
    v[62:52] = 11'(e);
    v[51:0]  = ($urandom_range(0, 3) == 0) ? (a[51:0] ^ {44'd0, r[7:0]}) : r[51:0];
    return v;
  endfunction

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic sub);
    fp_a_in = a;
    fp_b_in = b;
    is_sub  = sub;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] expected);
    vectors++;
    assert (fp_res_out === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, fp_res_out, expected);
    end
  endtask

  logic [63:0] dirA [13] = '{
    64'h3FF0000000000000, 64'h4008000000000000, 64'h3FF8000000000000,
    64'hC000000000000000, 64'hBFF0000000000000, 64'h4014000000000000,
    64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000,
    64'h0000000000000001, 64'h3FF0000000000001, 64'h7FEFFFFFFFFFFFFF,
    64'h8000000000000000};
  logic [63:0] dirB [13] = '{
    64'h4000000000000000, 64'h3FF8000000000000, 64'h4008000000000000,
    64'hBFF0000000000000, 64'hC000000000000000, 64'hC014000000000000,
    64'h3FF0000000000000, 64'h7FF0000000000000, 64'h3FF0000000000000,
    64'h0000000000000001, 64'h3CA0000000000000, 64'h7FEFFFFFFFFFFFFF,
    64'h0000000000000000};
  logic dirSub [13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                        1'b0, 1'b0, 1'b0, 1'b1};
  logic [63:0] dirExp [13] = '{
    64'h4008000000000000, 64'h3FF8000000000000, 64'hBFF8000000000000,
    64'hC008000000000000, 64'h3FF0000000000000, 64'h0000000000000000,
    64'h7FF0000000000000, 64'h7FF8000000000000, 64'h7FF8000000000000,
    64'h0000000000000002, 64'h3FF0000000000002, 64'h7FF0000000000000,
    64'h8000000000000000};

  initial begin
    logic [63:0] a, b;
    logic        sub;

    applyStimulus(64'h3FF0000000000000, 64'h4000000000000000, 1'b0);
    #1;
    checkOutput("reset_async_hold", 64'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_edges_hold", 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first_edge_capture", 64'h4008000000000000);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(dirA[i], dirB[i], dirSub[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("directed%0d", i), dirExp[i]);
    end

    applyStimulus(64'h4008000000000000, 64'h3FF8000000000000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async_clear", 64'h0);
    @(posedge clk);
    #1;
    checkOutput("reset_discard", 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release_before_edge", 64'h0);
    @(posedge clk);
    #1;
    checkOutput("capture_after_release", 64'h3FF8000000000000);

    for (int i = 0; i < 3000; i++) begin
      a   = randOperand();
      b   = ($urandom_range(0, 1) == 1) ? nearOperand(a) : randOperand();
      sub = 1'($urandom_range(0, 1));
      applyStimulus(a, b, sub);
      @(posedge clk);
      #1;
      checkOutput($sformatf("rand%0d a=%h b=%h sub=%0b", i, a, b, sub),
                  refAddSub(a, b, sub));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
